// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// FSM states, header field positions and link limits.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_e;

  localparam int LEN_MSB  = 5;
  localparam int LEN_LSB  = 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;
  localparam int MAX_LEN  = 15;
  localparam int NUM_CHAN = 3;

  function automatic logic [7:0] make_header(
    input logic [3:0] len,
    input logic [1:0] dest
  );
    logic [7:0] h;
    h = '0;
    h[LEN_MSB:LEN_LSB]   = len;
    h[DEST_MSB:DEST_LSB] = dest;
    return h;
  endfunction

endpackage

// File: rtl/tx_payload_fifo.sv
// Payload FIFO: push/pop with occupancy count, head visible combinationally.
// Ports: clk, rst, push, push_data, pop, head, count.
module tx_payload_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [4:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + {4'b0, push} - {4'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/router_packet_tx.sv
// Packet transmitter: buffers payload, then emits header/payload/parity burst.
// Ports: host write/send side, rtr_busy in, pkt_valid/pkt_data/done/reject out.
module router_packet_tx
  import router_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_full,
  output logic [4:0] buf_count,
  input  logic       send,
  input  logic [1:0] send_dest,
  input  logic       send_inject_err,
  output logic       send_ready,
  input  logic       rtr_busy,
  output logic       pkt_valid,
  output logic [7:0] pkt_data,
  output logic       done,
  output logic       reject
);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e        state_q, state_d;
  logic [1:0]    dest_q, dest_d;
  logic [3:0]    len_q, len_d;
  logic          inj_q, inj_d;
  logic [3:0]    rem_q, rem_d;
  logic [7:0]    par_q, par_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          rej_pend_q, rej_pend_d;
  logic          reject_q, reject_d;

  logic       push, pop, start;
  logic [7:0] head;
  logic [4:0] count;

  tx_payload_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign send_ready = (state_q == IDLE) && !rtr_busy && !rst;
  assign wr_full    = (count == 5'(MAX_LEN)) || (state_q != IDLE);
  assign push       = wr_en && !wr_full && !start;

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    inj_d      = inj_q;
    rem_d      = rem_q;
    par_d      = par_q;
    gap_d      = gap_q;
    valid_d    = 1'b0;
    data_d     = 8'h00;
    done_d     = 1'b0;
    rej_pend_d = 1'b0;
    // Reject is staged one cycle so it lines up with where a header would be.
    reject_d   = rej_pend_q;
    pop        = 1'b0;
    start      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send && send_ready) begin
          if (count != 5'd0 && send_dest < 2'(NUM_CHAN)) begin
            start   = 1'b1;
            state_d = HEADER;
            dest_d  = send_dest;
            len_d   = count[3:0];
            inj_d   = send_inject_err;
          end else begin
            rej_pend_d = 1'b1;
          end
        end
      end
      HEADER: begin
        valid_d = 1'b1;
        data_d  = make_header(len_q, dest_q);
        par_d   = make_header(len_q, dest_q);
        rem_d   = len_q;
        state_d = PAYLOAD;
      end
      PAYLOAD: begin
        valid_d = 1'b1;
        data_d  = head;
        pop     = 1'b1;
        par_d   = par_q ^ head;
        rem_d   = rem_q - 4'd1;
        if (rem_q == 4'd1) state_d = PARITY;
      end
      PARITY: begin
        valid_d = 1'b1;
        data_d  = {par_q[7:1], par_q[0] ^ inj_q};
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        done_d = (gap_q == '0);
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      len_q      <= '0;
      inj_q      <= 1'b0;
      rem_q      <= '0;
      par_q      <= '0;
      gap_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      done_q     <= 1'b0;
      rej_pend_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      inj_q      <= inj_d;
      rem_q      <= rem_d;
      par_q      <= par_d;
      gap_q      <= gap_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      done_q     <= done_d;
      rej_pend_q <= rej_pend_d;
      reject_q   <= reject_d;
    end
  end

  assign buf_count = count;
  assign pkt_valid = valid_q;
  assign pkt_data  = data_q;
  assign done      = done_q;
  assign reject    = reject_q;

endmodule

// File: tb/tb_router_packet_tx.sv
// Bench for router_packet_tx: directed plan plus random packets
// checked against a queue-based packet model.
module tb_router_packet_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic [4:0] buf_count;
  logic       send;
  logic [1:0] send_dest;
  logic       send_inject_err;
  logic       send_ready;
  logic       rtr_busy;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       done;
  logic       reject;

  int total = 0;
  int bad   = 0;
  logic [7:0] mq[$];

  always #5 clk = ~clk;

  router_packet_tx #(.DEPTH(16), .GAP_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .wr_full         (wr_full),
    .buf_count       (buf_count),
    .send            (send),
    .send_dest       (send_dest),
    .send_inject_err (send_inject_err),
    .send_ready      (send_ready),
    .rtr_busy        (rtr_busy),
    .pkt_valid       (pkt_valid),
    .pkt_data        (pkt_data),
    .done            (done),
    .reject          (reject)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    chk("wr_full", {31'd0, wr_full}, {31'd0, mq.size() >= 15});
    wr_en   = 1'b1;
    wr_data = b;
    if (mq.size() < 15) mq.push_back(b);
    tick();
    wr_en = 1'b0;
    chk("buf_count", {27'd0, buf_count}, mq.size());
  endtask

  task automatic snd(input logic [1:0] d, input logic inj);
    int         len;
    logic [7:0] exp[$];
    logic [7:0] p;
    len             = mq.size();
    send            = 1'b1;
    send_dest       = d;
    send_inject_err = inj;
    tick();
    send            = 1'b0;
    send_inject_err = 1'b0;
    chk("pre_valid", {31'd0, pkt_valid}, 0);
    if (len == 0 || d == 2'd3) begin
      tick();
      chk("reject", {31'd0, reject}, 1);
      chk("rej_novalid", {31'd0, pkt_valid}, 0);
      chk("rej_count", {27'd0, buf_count}, len);
      tick();
      chk("reject_end", {31'd0, reject}, 0);
      chk("rej_novalid2", {31'd0, pkt_valid}, 0);
    end else begin
      exp.push_back(8'(len * 4 + d));
      repeat (len) exp.push_back(mq.pop_front());
      p = 8'h00;
      foreach (exp[i]) p = p ^ exp[i];
      if (inj) p = p ^ 8'h01;
      exp.push_back(p);
      foreach (exp[i]) begin
        tick();
        chk($sformatf("valid[%0d]", i), {31'd0, pkt_valid}, 1);
        chk($sformatf("data[%0d]", i), {24'd0, pkt_data}, {24'd0, exp[i]});
      end
      tick();
      chk("gap1_valid", {31'd0, pkt_valid}, 0);
      chk("gap1_data", {24'd0, pkt_data}, 0);
      chk("done", {31'd0, done}, 1);
      chk("gap1_ready", {31'd0, send_ready}, 0);
      tick();
      chk("gap2_valid", {31'd0, pkt_valid}, 0);
      chk("done_end", {31'd0, done}, 0);
      chk("drained", {27'd0, buf_count}, 0);
      chk("ready_back", {31'd0, send_ready}, 1);
    end
  endtask

  initial begin
    int n;
    logic [7:0] b1;
    rst             = 1'b1;
    wr_en           = 1'b0;
    wr_data         = 8'h00;
    send            = 1'b0;
    send_dest       = 2'd0;
    send_inject_err = 1'b0;
    rtr_busy        = 1'b0;
    #2;
    chk("rst_valid", {31'd0, pkt_valid}, 0);
    chk("rst_data", {24'd0, pkt_data}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_reject", {31'd0, reject}, 0);
    chk("rst_ready", {31'd0, send_ready}, 0);
    chk("rst_full", {31'd0, wr_full}, 0);
    chk("rst_count", {27'd0, buf_count}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("ready_init", {31'd0, send_ready}, 1);

    // basic packet, then the same payload with parity corrupted
    wr(8'hAA); wr(8'h55); wr(8'h0F);
    snd(2'd1, 1'b0);
    wr(8'hAA); wr(8'h55); wr(8'h0F);
    snd(2'd1, 1'b1);

    // illegal sends
    snd(2'd0, 1'b0);
    wr(8'h77);
    snd(2'd3, 1'b0);
    chk("dest3_keep", {27'd0, buf_count}, 1);
    snd(2'd0, 1'b0);

    // full buffer, dropped 16th write, max-length packet
    for (int i = 1; i <= 15; i++) wr(8'(i));
    chk("full_high", {31'd0, wr_full}, 1);
    wr(8'hFF);
    chk("full_count", {27'd0, buf_count}, 15);
    snd(2'd2, 1'b0);

    // busy router: send ignored
    wr(8'h3C);
    rtr_busy = 1'b1;
    #1;
    chk("busy_ready", {31'd0, send_ready}, 0);
    send = 1'b1;
    tick();
    send = 1'b0;
    tick();
    chk("busy_novalid", {31'd0, pkt_valid}, 0);
    chk("busy_noreject", {31'd0, reject}, 0);
    chk("busy_count", {27'd0, buf_count}, 1);
    rtr_busy = 1'b0;
    snd(2'd0, 1'b0);

    // random packets
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 15);
      for (int i = 0; i < n; i++) wr(8'($urandom));
      snd(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // reset during the second payload byte
    b1 = 8'($urandom);
    wr(8'h11); wr(b1); wr(8'h33);
    send      = 1'b1;
    send_dest = 2'd0;
    tick();
    send = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_byte2", {24'd0, pkt_data}, {24'd0, b1});
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, pkt_valid}, 0);
    chk("mid_rst_data", {24'd0, pkt_data}, 0);
    chk("mid_rst_count", {27'd0, buf_count}, 0);
    chk("mid_rst_ready", {31'd0, send_ready}, 0);
    #2;
    rst = 1'b0;
    mq.delete();
    tick();
    snd(2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_packet_tx.md
# router_packet_tx

Packet transmitter for the 3-channel router link: host loads a payload into an internal buffer, then issues a send with destination; block emits header, payload and parity bytes on the router's ingress interface (`pkt_valid`/`pkt_data`) as one contiguous burst. It sits upstream of the router, on the driving side of the same header/length/parity protocol the router checks.

## Interface
Parameters:
- `DEPTH`, 16: payload buffer entries; only 15 are usable because the length field is 4 bits.
- `GAP_CYCLES`, 2: minimum idle cycles with `pkt_valid` low after each parity byte; must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_en` in 1: push `wr_data` into the payload buffer.
- `wr_data` in 8: payload byte.
- `wr_full` out 1: write not accepted this cycle.
- `buf_count` out 5: bytes currently buffered (0..15).
- `send` in 1: start a packet, sampled only when `send_ready` = 1.
- `send_dest` in 2: destination channel 0..2.
- `send_inject_err` in 1: invert bit 0 of the parity byte (test hook).
- `send_ready` out 1: block is idle and `rtr_busy` is low.
- `rtr_busy` in 1: router busy flag.
- `pkt_valid` out 1: byte valid on `pkt_data`.
- `pkt_data` out 8: header, payload or parity byte.
- `done` out 1: one-cycle pulse after a packet completes.
- `reject` out 1: one-cycle pulse after an illegal send.

## Operation
- Header byte is {2'b00, len[3:0], dest[1:0]}, where len = `buf_count` at the cycle `send` is sampled.
- Parity byte is the XOR of the header and every payload byte, with bit 0 inverted when `send_inject_err` was set at send time.
- Dest, len and inject are latched at send time.
- Payload buffer:
  - FIFO, `DEPTH` entries, count saturates at 15.
  - `wr_full` = (count == 15) || state != IDLE.
  - A write while `wr_full` is high is dropped silently.
  - A write in the same cycle as an accepted `send` is dropped.
- FSM states:
  - IDLE: on `send` && `send_ready`, go to HEADER if 1 ≤ count ≤ 15 and dest ≠ 3. Otherwise pulse `reject` on the next cycle, stay in IDLE, keep the buffer intact.
  - HEADER: drive the header, go to PAYLOAD.
  - PAYLOAD: pop one byte per cycle for len cycles, go to PARITY after the last byte.
  - PARITY: drive the parity byte, go to GAP.
  - GAP: `pkt_valid` low for `GAP_CYCLES` cycles, `done` pulses in the first GAP cycle, then return to IDLE.
- `pkt_valid` is never deasserted mid-packet. The router flags a dropped `pkt_valid` as an error, so there is no stall path and `rtr_busy` is checked only in IDLE.
- `send` while not ready is ignored: no reject, no state change.

## Timing
- Reset values: `pkt_valid`=0, `pkt_data`=0x00, `done`=0, `reject`=0, `send_ready`=0 while `rst` is high, `wr_full`=0, `buf_count`=0. State is IDLE and the buffer pointers are cleared.
- Send sampled at edge N:
  - header on `pkt_valid`/`pkt_data` from edge N+1;
  - payload bytes at N+2 .. N+1+len;
  - parity at N+2+len.
- Burst length is len+2 consecutive valid cycles. `done` is high in cycle N+3+len.
- `reject` is high exactly one cycle, at N+1.
- `pkt_valid` and `pkt_data` are registered outputs. `pkt_data` = 0x00 whenever `pkt_valid` = 0.
- Parity accumulates incrementally, one XOR per emitted byte. There is no combinational read-ahead beyond the FIFO head.
- Buffer pointers are 4-bit and wrap mod 16. Count is the occupancy and is kept separate from the pointers.
- `rst` asserted mid-packet: outputs drop to reset values immediately (asynchronous), the buffer empties, and the partial packet is abandoned. The router then sees `pkt_valid` fall and flags its own error.

## Structure
- Package `router_pkg` holds:
  - FSM state enum (IDLE, HEADER, PAYLOAD, PARITY, GAP);
  - header field positions: LEN_MSB=5, LEN_LSB=2, DEST_MSB=1, DEST_LSB=0;
  - `MAX_LEN`=15;
  - `NUM_CHAN`=3.
- One sub-module: `tx_payload_fifo`, a synchronous FIFO with push/pop/count and head data visible combinationally. The top level holds the FSM, latches and parity accumulator.

## Test plan
- Write 0xAA, 0x55, 0x0F, then send dest=1 → burst 0x0D, 0xAA, 0x55, 0x0F, 0xFD with `pkt_valid` high for 5 cycles, then `done` pulse and ≥2 idle cycles.
- Same payload with `send_inject_err`=1 → parity byte 0xFC, all other bytes unchanged.
- Send with empty buffer, and send with dest=3 after writing 1 byte → `reject` pulses, no `pkt_valid`, and in the dest=3 case `buf_count` stays 1.
- Write 0x01..0x0F, then a 16th write of 0xFF → `wr_full` high, 0xFF dropped. Send dest=2 → header 0x3E, 15 payload bytes, parity 0x3E.
- Hold `rtr_busy`=1 and pulse `send` → ignored. Drop `rtr_busy`, send again → burst starts next cycle.
- Assert `rst` during the 2nd payload byte → `pkt_valid`=0 the same cycle, `buf_count`=0, and a subsequent send with an empty buffer rejects.
